// File: rtl/rr_arb_mux.sv
// Single-register channel mux with fixed-select or round-robin arbitration.
// in_ready is a combinational function of valid/select/out_ready, never of in_data.
module rr_arb_mux #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SELW-1:0]   last_grant;
    logic [SELW-1:0]   rr_ch;
    logic              rr_found;
    int unsigned       rr_idx;
    logic [SELW-1:0]   grant_ch;
    logic              grant_ok;
    logic              load_en;
    logic              xfer;
    logic [WIDTH-1:0]  ch_data [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search starting one past the last round-robin grant.
    always_comb begin
        rr_found = 1'b0;
        rr_ch    = '0;
        rr_idx   = 0;
        for (int unsigned off = 1; off <= NCH; off++) begin
            rr_idx = (32'(last_grant) + off) % NCH;
            if (!rr_found && in_valid[SELW'(rr_idx)]) begin
                rr_found = 1'b1;
                rr_ch    = SELW'(rr_idx);
            end
        end
    end

    always_comb begin
        grant_ch = sel;
        grant_ok = (32'(sel) < NCH);
        if (mode) begin
            grant_ch = rr_ch;
            grant_ok = rr_found;
        end
    end

    assign load_en = !out_valid || out_ready;
    assign xfer    = rst_n && grant_ok && load_en && in_valid[grant_ch];

    always_comb begin
        in_ready = '0;
        if (rst_n && grant_ok) begin
            in_ready[grant_ch] = load_en;
        end
    end

    // Output register occupancy FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (!xfer && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
        end else if (xfer) begin
            out_data <= ch_data[grant_ch];
            out_ch   <= grant_ch;
        end
    end

    // Only round-robin transfers advance the fairness pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SELW'(NCH - 1);
        end else if (xfer && mode) begin
            last_grant <= grant_ch;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: a reference model predicts grants and pushes
// expected words; the output register is compared against the queue head.
module tb_rr_arb_mux;

    localparam int unsigned WIDTH = 2;
    localparam int unsigned NCH   = 4;
    localparam int unsigned SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int checks   = 0;
    int failures = 0;

    logic [SELW+WIDTH-1:0] sb [$];
    logic                  m_valid;
    logic [SELW-1:0]       m_last;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, check, advance the model, wait a full clock.
    task automatic step(input logic [3:0] v, input logic md, input logic [1:0] s, input logic ordy);
        logic [3:0]            er;
        logic [1:0]            g;
        logic [1:0]            c;
        logic                  gok;
        logic [SELW+WIDTH-1:0] e;
        logic [7:0]            sh;
        in_valid  = v;
        mode      = md;
        sel       = s;
        out_ready = ordy;
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb[0];
                check("out_ch", 32'(out_ch), 32'(e[3:2]));
                check("out_data", 32'(out_data), 32'(e[1:0]));
            end
        end
        gok = 1'b0;
        g   = s;
        if (!md) begin
            gok = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                c = m_last + 2'(k);
                if (!gok && v[c]) begin
                    gok = 1'b1;
                    g   = c;
                end
            end
        end
        er = 4'b0000;
        if (gok && (!m_valid || ordy)) er[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        if (m_valid && ordy && sb.size() > 0) void'(sb.pop_front());
        if (er[g] && v[g]) begin
            sh = in_data >> (2 * int'(g));
            sb.push_back({g, sh[1:0]});
            m_valid = 1'b1;
            if (md) m_last = g;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        sb.delete();
        m_valid = 1'b0;
        m_last  = 2'd3;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'he4;
        in_valid  = 4'hf;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed mode walk 3..0, then drain.
        step(4'hf, 1'b0, 2'd3, 1'b1);
        step(4'hf, 1'b0, 2'd2, 1'b1);
        step(4'hf, 1'b0, 2'd1, 1'b1);
        step(4'hf, 1'b0, 2'd0, 1'b1);
        step(4'h0, 1'b0, 2'd0, 1'b1);
        step(4'h0, 1'b0, 2'd0, 1'b1);

        // Round-robin with all channels valid.
        for (int i = 0; i < 6; i++) step(4'hf, 1'b1, 2'd0, 1'b1);
        step(4'h0, 1'b1, 2'd0, 1'b1);

        // Only ch1 and ch3 requesting.
        for (int i = 0; i < 4; i++) step(4'ha, 1'b1, 2'd0, 1'b1);
        step(4'h0, 1'b1, 2'd0, 1'b1);

        // Backpressure while holding ch2.
        step(4'h4, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'hf, 1'b1, 2'd0, 1'b0);
        step(4'hf, 1'b1, 2'd0, 1'b1);
        step(4'h0, 1'b1, 2'd0, 1'b1);

        // Mode/sel changes while FULL leave the register untouched.
        step(4'h8, 1'b1, 2'd0, 1'b1);
        step(4'hf, 1'b0, 2'd1, 1'b0);
        step(4'hf, 1'b1, 2'd2, 1'b0);

        // Reset while FULL with ch3 data.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_ch", 32'(out_ch), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(4'h6, 1'b1, 2'd0, 1'b1);
        step(4'h0, 1'b1, 2'd0, 1'b1);

        // Fixed sel=1 with ch1 idle: pending word pops, nothing reloads.
        step(4'h2, 1'b0, 2'd1, 1'b1);
        step(4'hd, 1'b0, 2'd1, 1'b1);
        step(4'hd, 1'b0, 2'd1, 1'b1);

        // Random traffic with random per-channel data.
        for (int i = 0; i < 300; i++) begin
            in_data = 8'($urandom);
            step(4'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        end
        step(4'h0, 1'b1, 2'd0, 1'b1);
        step(4'h0, 1'b1, 2'd0, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
